// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache: word type, FSM state
// encoding and the fill line-address builder.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Rebuilds a byte address from tag/index/word-offset fields for a given geometry.
    function automatic word_t line_addr(input word_t tag, input word_t idx, input word_t ofs,
                                        input int unsigned ob, input int unsigned ib);
        return (tag << (ib + ob + 2)) | (idx << (ob + 2)) | (ofs << 2);
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side bundle of the instruction cache plus its counters.
interface icache_assoc_if;
    import icache_assoc_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  flush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    word_t hit_count;
    word_t miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_assoc_way.sv
// One cache way: per-set valid bit, tag and BLKWORDS-word line, with a
// combinational lookup port and a single-word fill write port.
module icache_assoc_way
    import icache_assoc_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2,
    parameter int TAGW     = 26,
    parameter int IDXW     = 3,
    parameter int OFSW     = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clr,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [TAGW-1:0] rd_tag,
    input  logic [OFSW-1:0] rd_ofs,
    output logic            match,
    output word_t           rdata,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [OFSW-1:0] wr_ofs,
    input  word_t           wr_data,
    input  logic            fin,
    input  logic [TAGW-1:0] fin_tag
);
    localparam int AW = $clog2(SETS * BLKWORDS);

    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags [SETS];
    word_t           data [SETS*BLKWORDS];
    logic [AW-1:0]   rd_a;
    logic [AW-1:0]   wr_a;

    assign rd_a = AW'(rd_idx) * AW'(BLKWORDS) + AW'(rd_ofs);
    assign wr_a = AW'(wr_idx) * AW'(BLKWORDS) + AW'(wr_ofs);

    // Invalidation beats a completing fill in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST || clr) valid <= '0;
        else if (fin)   valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wr_en) data[wr_a] <= wr_data;
        if (fin)   tags[wr_idx] <= fin_tag;
    end

    assign match = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rdata = data[rd_a];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word line fill, flush,
// round-robin replacement per set and saturating hit/miss counters.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input logic           CLK,
    input logic           RST,
    icache_assoc_if.slave bus
);
    localparam int OB   = $clog2(BLKWORDS);
    localparam int IB   = $clog2(SETS);
    localparam int TAGW = 30 - OB - IB;
    localparam int OFSW = (OB > 0) ? OB : 1;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    icache_state_t   state, next_state;
    logic [IB-1:0]   req_idx, fill_idx;
    logic [TAGW-1:0] req_tag, fill_tag;
    logic [OFSW-1:0] req_ofs, cnt;
    logic [WW-1:0]   victim;
    logic [WW-1:0]   rr [SETS];
    logic [WAYS-1:0] way_hit;
    word_t           way_data [WAYS];
    logic            any_hit, lookup, miss, step, last, fin;
    word_t           hit_cnt, miss_cnt;

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [WW-1:0] next_ptr(input logic [WW-1:0] p);
        return (WAYS == 1) ? '0 : WW'((int'(p) + 1) % WAYS);
    endfunction

    // Block offset masks to zero when a line is a single word.
    assign req_ofs = OFSW'((bus.imemaddr >> 2) & word_t'(BLKWORDS - 1));
    assign req_idx = IB'(bus.imemaddr >> (2 + OB));
    assign req_tag = TAGW'(bus.imemaddr >> (2 + OB + IB));

    assign any_hit = |way_hit;
    assign lookup  = (state == IDLE) && bus.imemREN && !bus.flush;
    assign miss    = lookup && !any_hit;
    assign step    = (state == FILL) && !bus.iwait;
    assign last    = step && (cnt == OFSW'(BLKWORDS - 1));
    assign fin     = last && !bus.flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel = (victim == WW'(w));
        icache_assoc_way #(
            .SETS(SETS), .BLKWORDS(BLKWORDS), .TAGW(TAGW), .IDXW(IB), .OFSW(OFSW)
        ) u_way (
            .CLK(CLK), .RST(RST), .clr(bus.flush),
            .rd_idx(req_idx), .rd_tag(req_tag), .rd_ofs(req_ofs),
            .match(way_hit[w]), .rdata(way_data[w]),
            .wr_en(step && sel), .wr_idx(fill_idx), .wr_ofs(cnt), .wr_data(bus.iload),
            .fin(fin && sel), .fin_tag(fill_tag)
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss) next_state = FILL;
            FILL:    if (bus.flush || last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (state)
            IDLE: begin
                bus.ihit = lookup && any_hit;
                for (int w = 0; w < WAYS; w++)
                    if (lookup && way_hit[w]) bus.imemload = way_data[w];
            end
            FILL: begin
                bus.iREN  = 1'b1;
                bus.iaddr = line_addr(word_t'(fill_tag), word_t'(fill_idx), word_t'(cnt), OB, IB);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)       cnt <= '0;
        else if (miss) cnt <= '0;
        else if (step) cnt <= cnt + OFSW'(1);
    end

    // Fill target captured at the miss; the fetch port is free to change afterwards.
    always_ff @(posedge CLK) begin
        if (miss) begin
            fill_idx <= req_idx;
            fill_tag <= req_tag;
            victim   <= rr[req_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (fin) begin
            rr[fill_idx] <= next_ptr(rr[fill_idx]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (bus.ihit) hit_cnt  <= sat_inc(hit_cnt);
            if (miss)     miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: table of directed fetches, flush/reset/deassert
// sequences, counter saturation and random fetches against a set/way model.
module tb_icache_assoc;
    import icache_assoc_pkg::*;

    localparam int SETS = 8, WAYS = 2, BLKWORDS = 2;
    localparam word_t PAT = 32'hA5A5_A5A5;

    typedef struct {
        word_t addr;
        bit    hit0;
        word_t data;
        word_t hc;
        word_t mc;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    icache_assoc_if bus ();
    icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    // Memory: word at A holds A^PAT, ready after mem_lat wait cycles per word.
    int unsigned mem_lat = 2;
    logic [3:0]  wcnt;
    always @(posedge CLK) begin
        if (!bus.iREN || !bus.iwait) wcnt <= '0;
        else                         wcnt <= wcnt + 4'd1;
    end
    assign bus.iwait = !(bus.iREN && (32'(wcnt) >= mem_lat));
    assign bus.iload = bus.iaddr ^ PAT;

    word_t fill_log[$];
    always @(negedge CLK) if (bus.iREN && !bus.iwait) fill_log.push_back(bus.iaddr);

    int tests = 0, fails = 0;

    bit    mv  [SETS][WAYS];
    word_t mt  [SETS][WAYS];
    int    mrr [SETS];
    word_t exp_hit, exp_miss;

    function automatic word_t sat(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic int set_of(input word_t a);
        return int'((a / word_t'(4 * BLKWORDS)) % word_t'(SETS));
    endfunction

    function automatic word_t tag_of(input word_t a);
        return a / word_t'(4 * BLKWORDS * SETS);
    endfunction

    function automatic bit model_access(input word_t a, input bit refetch);
        int s;
        word_t t;
        s = set_of(a);
        t = tag_of(a);
        for (int w = 0; w < WAYS; w++)
            if (mv[s][w] && mt[s][w] == t) begin
                exp_hit = sat(exp_hit);
                return 1'b1;
            end
        exp_miss = sat(exp_miss);
        mv[s][mrr[s]] = 1'b1;
        mt[s][mrr[s]] = t;
        mrr[s] = (mrr[s] + 1) % WAYS;
        if (refetch) exp_hit = sat(exp_hit);
        return 1'b0;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
        exp_hit = '0;
        exp_miss = '0;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_hit_count"}, bus.hit_count, exp_hit);
        chk({name, "_miss_count"}, bus.miss_count, exp_miss);
    endtask

    task automatic check_fill(input word_t a);
        word_t base;
        base = a & ~word_t'(4 * BLKWORDS - 1);
        chk("fill_len", 32'(fill_log.size()), 32'(BLKWORDS));
        for (int i = 0; i < BLKWORDS; i++)
            if (i < fill_log.size()) chk("fill_addr", fill_log[i], base + word_t'(4 * i));
    endtask

    // Starts and ends at posedge+1; holds imemREN until ihit is seen.
    task automatic fetch(input word_t a, output bit hit0, output word_t data);
        int cyc = 0;
        bit done = 1'b0;
        hit0 = 1'b0;
        data = '0;
        fill_log.delete();
        bus.imemREN = 1'b1;
        bus.imemaddr = a;
        while (!done) begin
            @(negedge CLK);
            if (bus.ihit) begin
                done = 1'b1;
                hit0 = (cyc == 0);
                data = bus.imemload;
            end else if (cyc >= 60) begin
                done = 1'b1;
                tests++;
                fails++;
                $display("FAIL fetch_timeout addr %h: got no ihit, required ihit within 60 cycles", a);
            end else begin
                cyc++;
            end
            @(posedge CLK); #1;
        end
        bus.imemREN = 1'b0;
    endtask

    task automatic access_check(input word_t a, input string name);
        bit pred, h0;
        word_t d;
        pred = model_access(a, 1'b1);
        fetch(a, h0, d);
        chk({name, "_hit0"}, 32'(h0), 32'(pred));
        chk({name, "_data"}, d, a ^ PAT);
        if (!pred) check_fill(a);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  vecs [9];
        bit    h0, done;
        word_t d;

        vecs[0] = '{32'h040, 1'b0, 32'hA5A5A5E5, 32'd1, 32'd1};
        vecs[1] = '{32'h044, 1'b1, 32'hA5A5A5E1, 32'd2, 32'd1};
        vecs[2] = '{32'h0C0, 1'b0, 32'hA5A5A565, 32'd3, 32'd2};
        vecs[3] = '{32'h140, 1'b0, 32'hA5A5A4E5, 32'd4, 32'd3};
        vecs[4] = '{32'h0C0, 1'b1, 32'hA5A5A565, 32'd5, 32'd3};
        vecs[5] = '{32'h040, 1'b0, 32'hA5A5A5E5, 32'd6, 32'd4};
        vecs[6] = '{32'h144, 1'b1, 32'hA5A5A4E1, 32'd7, 32'd4};
        vecs[7] = '{32'h048, 1'b0, 32'hA5A5A5ED, 32'd8, 32'd5};
        vecs[8] = '{32'h04C, 1'b1, 32'hA5A5A5E9, 32'd9, 32'd5};

        RST = 1'b1;
        bus.imemREN = 1'b0;
        bus.imemaddr = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        @(negedge CLK);
        chk("rst_ihit", 32'(bus.ihit), 32'd0);
        chk("rst_iREN", 32'(bus.iREN), 32'd0);
        chk("rst_iaddr", bus.iaddr, 32'd0);
        chk("rst_imemload", bus.imemload, 32'd0);
        chk_counts("rst");
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) begin
            void'(model_access(vecs[i].addr, 1'b1));
            fetch(vecs[i].addr, h0, d);
            chk("vec_hit0", 32'(h0), 32'(vecs[i].hit0));
            chk("vec_data", d, vecs[i].data);
            chk("vec_hit_count", bus.hit_count, vecs[i].hc);
            chk("vec_miss_count", bus.miss_count, vecs[i].mc);
            if (!vecs[i].hit0) check_fill(vecs[i].addr);
            else chk("vec_no_fill", 32'(fill_log.size()), 32'd0);
        end

        // Flush while a hit is being requested in IDLE.
        bus.imemREN = 1'b1;
        bus.imemaddr = 32'h040;
        bus.flush = 1'b1;
        @(negedge CLK);
        chk("flush_idle_ihit", 32'(bus.ihit), 32'd0);
        @(posedge CLK); #1;
        bus.flush = 1'b0;
        bus.imemREN = 1'b0;
        model_flush();
        chk_counts("flush_idle");
        access_check(32'h048, "post_flush");
        access_check(32'h040, "refill");

        // Flush on the last word of a fill: nothing may become valid.
        mem_lat = 0;
        bus.imemREN = 1'b1;
        bus.imemaddr = 32'h200;
        @(negedge CLK);
        chk("abort_first_ihit", 32'(bus.ihit), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_iREN", 32'(bus.iREN), 32'd1);
        chk("abort_iaddr", bus.iaddr, 32'h200);
        @(posedge CLK); #1;
        bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.flush = 1'b0;
        bus.imemREN = 1'b0;
        @(negedge CLK);
        chk("abort_iREN_after", 32'(bus.iREN), 32'd0);
        chk("abort_iaddr_after", bus.iaddr, 32'd0);
        chk("abort_ihit_after", 32'(bus.ihit), 32'd0);
        @(posedge CLK); #1;
        exp_miss = sat(exp_miss);
        model_flush();
        chk_counts("abort");
        mem_lat = 2;
        access_check(32'h044, "abort_a");
        access_check(32'h200, "abort_b");

        // Reset in the middle of a fill.
        bus.imemREN = 1'b1;
        bus.imemaddr = 32'h300;
        @(posedge CLK); #1;
        chk("rstfill_iREN", 32'(bus.iREN), 32'd1);
        RST = 1'b1;
        bus.imemREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("rstfill_iREN_after", 32'(bus.iREN), 32'd0);
        chk("rstfill_ihit_after", 32'(bus.ihit), 32'd0);
        chk_counts("rstfill");
        @(posedge CLK); #1;
        access_check(32'h044, "post_rst");

        // Fetch request withdrawn right after the miss; fill must still complete.
        fill_log.delete();
        bus.imemREN = 1'b1;
        bus.imemaddr = 32'h080;
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
        bus.imemaddr = 32'h3FC;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (!bus.iREN) done = 1'b1;
            @(posedge CLK); #1;
        end
        chk("drop_fill_done", 32'(done), 32'd1);
        void'(model_access(32'h080, 1'b0));
        check_fill(32'h080);
        chk_counts("drop");
        access_check(32'h084, "drop_hit");

        // Miss counter saturation.
        force dut.miss_cnt = 32'hFFFF_FFFF;
        @(posedge CLK); #1;
        release dut.miss_cnt;
        exp_miss = 32'hFFFF_FFFF;
        access_check(32'h388, "sat");
        chk("sat_miss_count", bus.miss_count, 32'hFFFF_FFFF);

        // Random fetches with random memory latency and occasional flushes.
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        for (int n = 0; n < 250; n++) begin
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) begin
                bus.flush = 1'b1;
                @(posedge CLK); #1;
                bus.flush = 1'b0;
                model_flush();
            end
            access_check(word_t'($urandom_range(0, 127)) << 2, "rnd");
            if (n % 25 == 24) chk_counts("rnd");
        end
        chk_counts("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
